// File: rtl/multicycle_main_ctrl.sv
// Main control FSM for the multi-cycle RV32I core: sequences fetch/decode/execute/memory/write-back.
// Latency: 2-5 cycles per instruction with zero wait states; outputs are combinational from state.
// Backpressure: FETCH, MEM_RD and MEM_WR hold (outputs constant) until mem_ready_i is high.
module multicycle_main_ctrl #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [6:0]          opcode_i,
  input  logic                mem_ready_i,
  output logic                pc_write_o,
  output logic                pc_write_cond_o,
  output logic                ir_write_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                reg_write_o,
  output logic [1:0]          ALUop_o,
  output logic                alu_imm_o,
  output logic [1:0]          alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [1:0]          pc_src_o,
  output logic [1:0]          mem_to_reg_o,
  output logic                instr_done_o,
  output logic                illegal_o,
  output logic [3:0]          state_o,
  output logic [RETIRE_W-1:0] retired_o
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_ALU   = 4'd7,
    WB_MEM   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10
  } state_t;

  state_t state;
  state_t state_nxt;

  // Raw strobes before reset gating; reset must suppress every write side effect.
  logic pc_write_raw;
  logic pc_write_cond_raw;
  logic ir_write_raw;
  logic mem_write_raw;
  logic reg_write_raw;
  logic done_raw;
  logic illegal_raw;

  // State register; reset restarts at FETCH so a partial instruction is abandoned.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next-state and per-state datapath controls; everything not set for a state stays 0.
  always_comb begin
    state_nxt         = state;
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    ir_write_raw      = 1'b0;
    mem_write_raw     = 1'b0;
    reg_write_raw     = 1'b0;
    done_raw          = 1'b0;
    illegal_raw       = 1'b0;
    mem_read_o        = 1'b0;
    ALUop_o           = 2'b00;
    alu_imm_o         = 1'b0;
    alu_src_a_o       = 2'b00;
    alu_src_b_o       = 2'b00;
    pc_src_o          = 2'b00;
    mem_to_reg_o      = 2'b00;
    case (state)
      FETCH: begin
        mem_read_o   = 1'b1;
        alu_src_b_o  = 2'b01;
        ir_write_raw = mem_ready_i;
        pc_write_raw = mem_ready_i;
        if (mem_ready_i) state_nxt = DECODE;
      end
      DECODE: begin
        // ALUOut latches old PC + imm here for BEQ/JAL targets.
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b10;
        case (opcode_i)
          OP_R:             state_nxt = EXEC_R;
          OP_I:             state_nxt = EXEC_I;
          OP_LW, OP_SW:     state_nxt = MEM_ADDR;
          OP_BEQ:           state_nxt = BRANCH;
          OP_JAL, OP_JALR:  state_nxt = JUMP;
          default: begin
            illegal_raw = 1'b1;
            state_nxt   = FETCH;
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a_o = 2'b01;
        ALUop_o     = 2'b10;
        state_nxt   = WB_ALU;
      end
      EXEC_I: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        ALUop_o     = 2'b10;
        alu_imm_o   = 1'b1;
        state_nxt   = WB_ALU;
      end
      MEM_ADDR: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        state_nxt   = (opcode_i == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read_o = 1'b1;
        if (mem_ready_i) state_nxt = WB_MEM;
      end
      MEM_WR: begin
        mem_write_raw = 1'b1;
        done_raw      = mem_ready_i;
        if (mem_ready_i) state_nxt = FETCH;
      end
      WB_ALU: begin
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
        state_nxt     = FETCH;
      end
      WB_MEM: begin
        reg_write_raw = 1'b1;
        mem_to_reg_o  = 2'b01;
        done_raw      = 1'b1;
        state_nxt     = FETCH;
      end
      BRANCH: begin
        alu_src_a_o       = 2'b01;
        ALUop_o           = 2'b01;
        pc_write_cond_raw = 1'b1;
        pc_src_o          = 2'b01;
        done_raw          = 1'b1;
        state_nxt         = FETCH;
      end
      JUMP: begin
        reg_write_raw = 1'b1;
        mem_to_reg_o  = 2'b10;
        pc_write_raw  = 1'b1;
        done_raw      = 1'b1;
        state_nxt     = FETCH;
        if (opcode_i == OP_JALR) begin
          alu_src_a_o = 2'b01;
          alu_src_b_o = 2'b10;
          pc_src_o    = 2'b10;
        end else begin
          pc_src_o    = 2'b01;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  assign pc_write_o      = pc_write_raw      & rst_i;
  assign pc_write_cond_o = pc_write_cond_raw & rst_i;
  assign ir_write_o      = ir_write_raw      & rst_i;
  assign mem_write_o     = mem_write_raw     & rst_i;
  assign reg_write_o     = reg_write_raw     & rst_i;
  assign instr_done_o    = done_raw          & rst_i;
  assign illegal_o       = illegal_raw       & rst_i;
  assign state_o         = state;

  // Retired-instruction counter; wraps freely, illegal opcodes never reach instr_done.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)            retired_o <= '0;
    else if (instr_done_o) retired_o <= retired_o + RETIRE_W'(1);
  end

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Bench for multicycle_main_ctrl: per-instruction summaries from a behavioural model vs. observed cycles.
// Latency: one scoreboard record checked at each instr_done/illegal pulse.
// Backpressure: mem_ready_i wait states are scheduled by the stimulus per instruction.
module tb_multicycle_main_ctrl;
  localparam int RW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [6:0]    opcode_i = 7'd0;
  logic          mem_ready_i = 1'b1;
  logic          pc_write_o, pc_write_cond_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o;
  logic [1:0]    ALUop_o, alu_src_a_o, alu_src_b_o, pc_src_o, mem_to_reg_o;
  logic          alu_imm_o, instr_done_o, illegal_o;
  logic [3:0]    state_o;
  logic [RW-1:0] retired_o;

  multicycle_main_ctrl #(.RETIRE_W(RW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .ir_write_o(ir_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .reg_write_o(reg_write_o),
    .ALUop_o(ALUop_o), .alu_imm_o(alu_imm_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .pc_src_o(pc_src_o), .mem_to_reg_o(mem_to_reg_o),
    .instr_done_o(instr_done_o), .illegal_o(illegal_o), .state_o(state_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  // Summary of one instruction: its length, end-cycle controls and strobe cycle counts.
  typedef struct packed {
    logic [7:0] cyc;
    logic       ill;
    logic       done;
    logic [3:0] ret;
    logic [2:0] alu_mask;   // {saw 10, saw 01, saw 00}
    logic       imm;
    logic [3:0] n_rw, n_mw, n_mr, n_ir, n_pw, n_pwc;
    logic [1:0] m2r, psrc, sa, sb;
  } rec_t;

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_JAL = 5, C_JALR = 6, C_ILL = 7;

  rec_t          exp_q[$];
  int            vecs = 0;
  int            miscmp = 0;
  int            rec_idx = 0;
  bit            mon_en = 1'b0;
  logic [RW-1:0] model_ret = '0;

  function automatic logic [6:0] op_of(input int cls);
    logic [6:0] ill_tab [5] = '{7'h7f, 7'h00, 7'h37, 7'h17, 7'h73};
    case (cls)
      C_R:    return 7'b0110011;
      C_I:    return 7'b0010011;
      C_LW:   return 7'b0000011;
      C_SW:   return 7'b0100011;
      C_BEQ:  return 7'b1100011;
      C_JAL:  return 7'b1101111;
      C_JALR: return 7'b1100111;
      default: return ill_tab[$urandom_range(0, 4)];
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vecs++;
    if (got !== want) begin
      miscmp++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Behavioural model: instruction class + wait counts -> expected summary; then drive the cycles.
  task automatic run_instr(input int cls, input int wf, input int wm, input logic [6:0] op);
    rec_t e;
    int   lat;
    bit   memph;
    e = '0;
    memph = (cls == C_LW) || (cls == C_SW);
    case (cls)
      C_R, C_I:             lat = wf + 4;
      C_LW:                 lat = wf + 5 + wm;
      C_SW:                 lat = wf + 4 + wm;
      C_BEQ, C_JAL, C_JALR: lat = wf + 3;
      default:              lat = wf + 2;
    endcase
    e.cyc      = 8'(lat);
    e.ill      = (cls == C_ILL);
    e.done     = (cls != C_ILL);
    e.ret      = model_ret;
    e.alu_mask = (cls == C_R || cls == C_I) ? 3'b101 : (cls == C_BEQ) ? 3'b011 : 3'b001;
    e.imm      = (cls == C_I);
    e.n_rw     = (cls == C_R || cls == C_I || cls == C_LW || cls == C_JAL || cls == C_JALR) ? 4'd1 : 4'd0;
    e.n_mw     = (cls == C_SW) ? 4'(wm + 1) : 4'd0;
    e.n_mr     = 4'(wf + 1 + ((cls == C_LW) ? wm + 1 : 0));
    e.n_ir     = 4'd1;
    e.n_pw     = (cls == C_JAL || cls == C_JALR) ? 4'd2 : 4'd1;
    e.n_pwc    = (cls == C_BEQ) ? 4'd1 : 4'd0;
    e.m2r      = (cls == C_LW) ? 2'b01 : (cls == C_JAL || cls == C_JALR) ? 2'b10 : 2'b00;
    e.psrc     = (cls == C_BEQ || cls == C_JAL) ? 2'b01 : (cls == C_JALR) ? 2'b10 : 2'b00;
    e.sa       = (cls == C_BEQ || cls == C_JALR) ? 2'b01 : (cls == C_ILL) ? 2'b10 : 2'b00;
    e.sb       = (cls == C_JALR || cls == C_ILL) ? 2'b10 : 2'b00;
    exp_q.push_back(e);
    if (cls != C_ILL) model_ret = model_ret + RW'(1);
    for (int c = 0; c < lat; c++) begin
      opcode_i = op;
      if (c < wf)                                      mem_ready_i = 1'b0;
      else if (c == wf)                                mem_ready_i = 1'b1;
      else if (memph && c >= wf + 3 && c < wf + 3 + wm) mem_ready_i = 1'b0;
      else if (memph && c == wf + 3 + wm)              mem_ready_i = 1'b1;
      else                                             mem_ready_i = 1'($urandom_range(0, 1));
      @(posedge clk_i);
      #1;
    end
  endtask

  // Monitor: accumulate observations each cycle, compare against the queue at every end pulse.
  int         m_cyc, m_rw, m_mw, m_mr, m_ir, m_pw, m_pwc;
  logic [2:0] m_mask;
  logic       m_imm;
  rec_t       obs, want;
  initial begin
    m_cyc = 0; m_rw = 0; m_mw = 0; m_mr = 0; m_ir = 0; m_pw = 0; m_pwc = 0; m_mask = '0; m_imm = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!mon_en) begin
        m_cyc = 0; m_rw = 0; m_mw = 0; m_mr = 0; m_ir = 0; m_pw = 0; m_pwc = 0; m_mask = '0; m_imm = 1'b0;
      end else begin
        m_cyc++;
        m_rw  += int'(reg_write_o);
        m_mw  += int'(mem_write_o);
        m_mr  += int'(mem_read_o);
        m_ir  += int'(ir_write_o);
        m_pw  += int'(pc_write_o);
        m_pwc += int'(pc_write_cond_o);
        if (ALUop_o == 2'b00) m_mask[0] = 1'b1;
        if (ALUop_o == 2'b01) m_mask[1] = 1'b1;
        if (ALUop_o == 2'b10) m_mask[2] = 1'b1;
        if (alu_imm_o) m_imm = 1'b1;
        if (instr_done_o || illegal_o) begin
          obs = '{cyc: 8'(m_cyc), ill: illegal_o, done: instr_done_o, ret: retired_o,
                  alu_mask: m_mask, imm: m_imm, n_rw: 4'(m_rw), n_mw: 4'(m_mw), n_mr: 4'(m_mr),
                  n_ir: 4'(m_ir), n_pw: 4'(m_pw), n_pwc: 4'(m_pwc), m2r: mem_to_reg_o,
                  psrc: pc_src_o, sa: alu_src_a_o, sb: alu_src_b_o};
          vecs++;
          if (exp_q.size() == 0) begin
            miscmp++;
            $display("FAIL unexpected_end rec%0d got %h want none", rec_idx, obs);
          end else begin
            want = exp_q.pop_front();
            if (obs !== want) begin
              miscmp++;
              $display("FAIL instr rec%0d got %h want %h", rec_idx, obs, want);
            end
          end
          rec_idx++;
          m_cyc = 0; m_rw = 0; m_mw = 0; m_mr = 0; m_ir = 0; m_pw = 0; m_pwc = 0; m_mask = '0; m_imm = 1'b0;
        end else if (m_cyc > 64) begin
          vecs++;
          miscmp++;
          $display("FAIL timeout rec%0d got %0d cycles want end pulse", rec_idx, m_cyc);
          m_cyc = 0;
        end
      end
    end
  end

  initial begin
    int cls, wf, wm;
    // Reset state: strobes gated even with mem_ready_i high.
    #12;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_mem_read", 32'(mem_read_o), 32'd1);
    chk("rst_ir_write", 32'(ir_write_o), 32'd0);
    chk("rst_pc_write", 32'(pc_write_o), 32'd0);
    chk("rst_aluop", 32'(ALUop_o), 32'd0);
    chk("rst_retired", 32'(retired_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i  = 1'b1;
    mon_en = 1'b1;
    // Directed pass covering every class, including LW with 2 fetch and 3 read waits (10 cycles).
    run_instr(C_R,    0, 0, op_of(C_R));
    run_instr(C_I,    0, 0, op_of(C_I));
    run_instr(C_LW,   2, 3, op_of(C_LW));
    run_instr(C_SW,   0, 0, op_of(C_SW));
    run_instr(C_BEQ,  0, 0, op_of(C_BEQ));
    run_instr(C_JAL,  0, 0, op_of(C_JAL));
    run_instr(C_JALR, 0, 0, op_of(C_JALR));
    run_instr(C_ILL,  0, 0, 7'b1111111);
    // Random pass; well over 16 retirements so the 4-bit counter wraps.
    for (int n = 0; n < 48; n++) begin
      cls = $urandom_range(0, 7);
      wf  = $urandom_range(0, 2);
      wm  = $urandom_range(0, 2);
      run_instr(cls, wf, wm, op_of(cls));
    end
    mon_en = 1'b0;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("retired_final", 32'(retired_o), 32'(model_ret));
    // Asynchronous reset in the middle of EXEC_R.
    opcode_i    = op_of(C_R);
    mem_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    chk("pre_rst_exec_r", 32'(state_o), 32'd2);
    #1;
    rst_i = 1'b0;
    #1;
    chk("async_rst_state", 32'(state_o), 32'd0);
    chk("async_rst_reg_write", 32'(reg_write_o), 32'd0);
    chk("async_rst_retired", 32'(retired_o), 32'd0);
    chk("async_rst_ir_write", 32'(ir_write_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("release_ir_write", 32'(ir_write_o), 32'd1);
    chk("release_state", 32'(state_o), 32'd0);
    @(posedge clk_i);
    #1;
    chk("release_decode", 32'(state_o), 32'd1);
    chk("release_no_retire", 32'(retired_o), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule

// File: doc/multicycle_main_ctrl.md
# multicycle_main_ctrl

Main control state machine for the multi-cycle RV32I core variant. It sequences the shared datapath through fetch, decode, execute, memory and write-back steps. It drives the 2-bit ALU opcode consumed by the ALU control decoder, plus all multiplexer selects and write strobes. It waits on a single-port instruction/data memory ready handshake and counts retired instructions.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `clk_i` input 1: system clock, rising edge.
- `rst_i` input 1: asynchronous, active-low reset.
- `opcode_i` input 7: opcode field of the instruction register. Stable from DECODE until the instruction ends.
- `mem_ready_i` input 1: memory completes the current read or write this cycle.
- `pc_write_o` output 1: unconditional PC load.
- `pc_write_cond_o` output 1: PC load qualified by the datapath zero flag (BEQ).
- `ir_write_o` output 1: instruction register load.
- `mem_read_o` output 1: memory read request.
- `mem_write_o` output 1: memory write request.
- `reg_write_o` output 1: register file write.
- `ALUop_o` output 2: to the ALU control decoder. 00 = add, 01 = subtract, 10 = decode by funct.
- `alu_imm_o` output 1: I-type ALU operation. The funct packer forces funct bit 3 to 0, so ADDI never becomes SUB.
- `alu_src_a_o` output 2: 00 = PC, 01 = rs1, 10 = old PC.
- `alu_src_b_o` output 2: 00 = rs2, 01 = constant 4, 10 = immediate.
- `pc_src_o` output 2: 00 = ALU result, 01 = ALUOut register, 10 = ALU result with bit 0 cleared.
- `mem_to_reg_o` output 2: 00 = ALUOut, 01 = MDR, 10 = old PC + 4 (link).
- `instr_done_o` output 1: one-cycle pulse in the final cycle of a legal instruction.
- `illegal_o` output 1: one-cycle pulse in DECODE on an unsupported opcode.
- `state_o` output 4: current state encoding, for debug.
- `retired_o` output RETIRE_W: count of completed legal instructions.

## Operation
- State encoding: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WR 6, WB_ALU 7, WB_MEM 8, BRANCH 9, JUMP 10. Codes 11–15 are unreachable and return to FETCH on the next edge.
- Supported opcodes: 0110011 (R-type), 0010011 (ADDI/ORI), 0000011 (LW), 0100011 (SW), 1100011 (BEQ), 1101111 (JAL), 1100111 (JALR).
- FETCH:
  - Outputs: mem_read = 1; a = PC, b = 4, ALUop = 00, pc_src = 00.
  - Both ir_write and pc_write equal mem_ready_i.
  - Holds while mem_ready_i = 0; goes to DECODE when it is 1.
- DECODE:
  - Outputs: a = old PC, b = immediate, ALUop = 00. ALUOut captures the branch/JAL target.
  - Next state by opcode: R → EXEC_R; ADDI/ORI → EXEC_I; LW/SW → MEM_ADDR; BEQ → BRANCH; JAL/JALR → JUMP.
  - Any other opcode pulses illegal_o and goes to FETCH.
- EXEC_R: a = rs1, b = rs2, ALUop = 10; next WB_ALU.
- EXEC_I: a = rs1, b = immediate, ALUop = 10, alu_imm = 1; next WB_ALU.
- MEM_ADDR: a = rs1, b = immediate, ALUop = 00; LW → MEM_RD, SW → MEM_WR.
- MEM_RD: mem_read = 1; holds until mem_ready_i = 1, then WB_MEM.
- MEM_WR:
  - mem_write = 1; holds until mem_ready_i = 1, then FETCH.
  - instr_done pulses in the ready cycle.
- WB_ALU: reg_write = 1, mem_to_reg = 00; next FETCH; instr_done = 1.
- WB_MEM: reg_write = 1, mem_to_reg = 01; next FETCH; instr_done = 1.
- BRANCH:
  - Outputs: a = rs1, b = rs2, ALUop = 01, pc_write_cond = 1, pc_src = 01.
  - Next FETCH; instr_done = 1.
- JUMP:
  - Common outputs: reg_write = 1, mem_to_reg = 10, pc_write = 1; next FETCH; instr_done = 1.
  - JAL: pc_src = 01.
  - JALR: a = rs1, b = immediate, ALUop = 00, pc_src = 10.
- Defaults: any output not listed for a state is 0.
- Outputs are combinational from the state register. The exceptions are ir_write, pc_write in FETCH, and instr_done in MEM_WR, which are also qualified by mem_ready_i.
- retired_o:
  - Increments by 1 on every edge where instr_done_o = 1.
  - Wraps modulo 2^RETIRE_W; no saturation.
  - Illegal opcodes do not increment it.

## Timing
- Reset (rst_i = 0, takes effect immediately):
  - State forced to FETCH; retired_o = 0.
  - All write strobes, instr_done_o and illegal_o are gated to 0 while reset is asserted.
  - mem_read_o = 1, ALUop_o = 00, state_o = 0.
- Reset released in mid-instruction: the controller restarts at FETCH. No partial write-back occurs.
- Zero-wait latency (cycles from FETCH entry to the next FETCH entry):
  - R / ADDI / ORI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ: 3.
  - JAL / JALR: 3.
  - Illegal opcode: 2.
- Wait states: each mem_ready_i = 0 cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle. Every output stays constant while waiting.
- mem_ready_i is ignored in all other states.
- Back-to-back instructions: the instr_done_o cycle is always followed directly by a FETCH cycle.

## Test plan
- **Reset:** assert rst_i mid-EXEC_R, asynchronously to the clock → state_o = 0, reg_write_o = 0 and retired_o = 0 before the next edge. Release reset with mem_ready_i = 1 → ir_write_o = 1 on the first cycle.
- **R-type and immediate:** opcode 0110011, then 0010011, with mem_ready_i held at 1 → each takes 4 cycles. Check ALUop_o = 10 in the execute state; alu_imm_o = 0 for the R-type and 1 for the immediate. retired_o goes from 0 to 2.
- **LW with wait states:** LW with mem_ready_i low for 2 cycles in FETCH and 3 cycles in MEM_RD → 10 cycles total. WB_MEM shows mem_to_reg_o = 01 and reg_write_o = 1.
- **SW:** 4 cycles; mem_write_o = 1 only in MEM_WR; reg_write_o is never asserted.
- **BEQ, JAL, JALR:** BEQ gives pc_write_cond_o = 1 with ALUop_o = 01. JAL gives pc_src_o = 01; JALR gives pc_src_o = 10. Both jumps show mem_to_reg_o = 10, and all three take 3 cycles.
- **Illegal opcode and counter wrap:**
  - opcode 1111111 → illegal_o pulses once, FETCH is re-entered after 2 cycles, retired_o is unchanged.
  - With RETIRE_W = 4, retire 16 instructions → retired_o wraps from 15 to 0.
